i2s_rx: RTL and testbench

- Receive-direction I2S deserializer, the capture counterpart of the playback serializer on the codec link.
- The codec is clock master. SCLK, LRCLK and ADC data arrive on ARDUINO_IO pins; the block runs entirely in the 50 MHz system clock domain.
- Each completed stereo frame is delivered as a left/right sample pair through a valid/ready handshake, for a FIFO or the SoC.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 34 +++
 rtl/i2s_rx.sv | 146 ++++++++++++++
 tb/tb_i2s_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and defaults for the I2S capture path
package i2s_pkg;

   typedef enum logic [1:0] {
      SYNC,
      LEFT,
      RIGHT
   } rx_state_t;

   localparam int SAMPLE_W_DEF = 16;
   localparam int SLOT_MAX_DEF = 32;

   localparam logic I2S_LEFT = 1'b0;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with registered rising-edge pulse
module sync_edge_det #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         edge_in,
   input  logic [W-1:0] data_in,
   output logic         rise,
   output logic [W-1:0] data_q
);

   logic [2:0]   edge_sr;
   logic [W-1:0] data_s1;
   logic [W-1:0] data_s2;

   // data_q is retimed by one extra stage so it lines up with the rise pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_sr <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
         data_q  <= '0;
         rise    <= 1'b0;
      end else begin
         edge_sr <= {edge_sr[1:0], edge_in};
         data_s1 <= data_in;
         data_s2 <= data_s1;
         data_q  <= data_s2;
         rise    <= edge_sr[1] & ~edge_sr[2];
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receive deserializer delivering stereo pairs over valid/ready
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int SLOT_MAX = SLOT_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sclk,
   input  logic                lrclk,
   input  logic                sdin,
   output logic [SAMPLE_W-1:0] left_data,
   output logic [SAMPLE_W-1:0] right_data,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun,
   input  logic                overrun_clr,
   output logic                locked
);

   localparam int CNT_W = $clog2(SLOT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SW   = CNT_W'(SAMPLE_W);

   logic                rise;
   logic [1:0]          rx_q;
   logic                lr_now;
   logic                sd_now;
   logic                lr_prev;
   logic                boundary;
   logic                slot_tmo;
   logic [CNT_W-1:0]    bit_cnt;
   logic [SAMPLE_W-1:0] shreg;
   logic [SAMPLE_W-1:0] shreg_d;
   logic [SAMPLE_W-1:0] left_hold;
   rx_state_t           state_q;
   rx_state_t           state_d;
   logic                latch_left;
   logic                pair_done;
   logic                go_sync;
   logic                drop;

   sync_edge_det #(.W(2)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .edge_in (sclk),
      .data_in ({lrclk, sdin}),
      .rise    (rise),
      .data_q  (rx_q)
   );

   assign lr_now   = rx_q[1];
   assign sd_now   = rx_q[0];
   assign boundary = rise && (lr_now != lr_prev);
   assign slot_tmo = rise && (lr_now == lr_prev) && (bit_cnt == CNT_LAST);

   always_comb begin
      shreg_d = shreg;
      for (int i = 0; i < SAMPLE_W; i++) begin
         if (i == SAMPLE_W - 1 - int'(bit_cnt)) shreg_d[i] = sd_now;
      end
   end

   // the boundary bit is the previous word's LSB, so it only restarts the slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lr_prev <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (rise) begin
         lr_prev <= lr_now;
         if (lr_now != lr_prev) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else begin
            if (bit_cnt < CNT_SW) shreg <= shreg_d;
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= SYNC;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      latch_left = 1'b0;
      pair_done  = 1'b0;
      go_sync    = 1'b0;
      case (state_q)
         SYNC: begin
            if (boundary && lr_now == I2S_LEFT) state_d = LEFT;
         end
         LEFT: begin
            if (boundary && lr_now != I2S_LEFT) begin
               latch_left = 1'b1;
               state_d    = RIGHT;
            end else if (slot_tmo) begin
               go_sync = 1'b1;
               state_d = SYNC;
            end
         end
         RIGHT: begin
            if (boundary && lr_now == I2S_LEFT) begin
               pair_done = 1'b1;
               state_d   = LEFT;
            end else if (slot_tmo) begin
               go_sync = 1'b1;
               state_d = SYNC;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   assign drop = pair_done && sample_valid && !sample_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         left_hold    <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         locked       <= 1'b0;
      end else begin
         if (latch_left) left_hold <= shreg;
         if (pair_done && !drop) begin
            left_data    <= left_hold;
            right_data   <= shreg;
            sample_valid <= 1'b1;
         end else if (sample_ready) begin
            sample_valid <= 1'b0;
         end
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
         if (go_sync)        locked <= 1'b0;
         else if (pair_done) locked <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for i2s_rx with slot-level reference model
module tb_i2s_rx;

   localparam int SW = 16;
   localparam int SM = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          sclk = 1'b0;
   logic          lrclk = 1'b1;
   logic          sdin = 1'b0;
   logic          sample_ready = 1'b0;
   logic          overrun_clr = 1'b0;
   logic [SW-1:0] left_data;
   logic [SW-1:0] right_data;
   logic          sample_valid;
   logic          overrun;
   logic          locked;

   i2s_rx #(.SAMPLE_W(SW), .SLOT_MAX(SM)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sdin         (sdin),
      .left_data    (left_data),
      .right_data   (right_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr),
      .locked       (locked)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [SW-1:0] l;
      logic [SW-1:0] r;
   } pair_t;

   pair_t   exp_q[$];
   int      n_vec = 0;
   int      n_err = 0;

   // slot-level model: 0 = unaligned, 1 = inside left slot, 2 = inside right slot
   int      phase = 0;
   int      mode = 0;
   bit      pending = 0;
   logic [SW-1:0] prev_cap = '0;
   logic [SW-1:0] left_val = '0;
   logic [SW-1:0] held_l = '0;
   logic [SW-1:0] held_r = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [SW-1:0] capture(input int nbits, input logic [63:0] bits);
      logic [SW-1:0] c = '0;
      for (int i = 0; i < nbits && i < SW; i++) c[SW-1-i] = bits[63-i];
      return c;
   endfunction

   task automatic pair_complete(input logic [SW-1:0] l, input logic [SW-1:0] r);
      pair_t p;
      p.l = l;
      p.r = r;
      if (mode == 1 && pending) return;
      exp_q.push_back(p);
      if (mode != 0) begin
         pending = 1;
         held_l  = l;
         held_r  = r;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      phase   = 0;
      pending = 0;
   endtask

   // one SCLK period = 8 clk; optional ready pulse lands on the pair-complete edge
   task automatic bit_out(input logic lr, input logic sd, input bit hit);
      sclk  = 1'b0;
      lrclk = lr;
      sdin  = sd;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (hit) begin
         repeat (3) @(posedge clk);
         #1 sample_ready = 1'b1;
         @(posedge clk);
         #1 sample_ready = 1'b0;
         @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_slot(input logic ch, input int nbits, input logic [63:0] bits,
                            input bit hit, input int reset_at);
      if (ch == 1'b0) begin
         if (phase == 2) pair_complete(left_val, prev_cap);
         phase = 1;
      end else if (phase == 1) begin
         left_val = prev_cap;
         phase    = 2;
      end
      bit_out(ch, ($urandom() & 1) != 0, hit);
      for (int i = 0; i < nbits; i++) begin
         if (i == reset_at) do_reset();
         bit_out(ch, bits[63-i], 1'b0);
      end
      prev_cap = capture(nbits, bits);
      if (nbits >= SM) phase = 0;
   endtask

   function automatic logic [63:0] rbits(input logic [SW-1:0] top);
      logic [63:0] b = {$urandom(), $urandom()};
      b[63:48] = top;
      return b;
   endfunction

   task automatic pulse_ready();
      @(posedge clk);
      #1 sample_ready = 1'b1;
      @(posedge clk);
      #1 sample_ready = 1'b0;
      pending = 0;
   endtask

   initial begin : monitor
      pair_t p;
      forever begin
         @(negedge clk);
         if (reset_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pair: got %h/%h expected none", left_data, right_data);
            end else begin
               p = exp_q.pop_front();
               check("pair_left", 32'(left_data), 32'(p.l));
               check("pair_right", 32'(right_data), 32'(p.r));
            end
         end
      end
   end

   initial begin : stim
      logic [63:0] b;
      repeat (5) @(negedge clk);
      check("rst_left", 32'(left_data), 32'h0);
      check("rst_right", 32'(right_data), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_valid", 32'(sample_valid), 32'h0);

      // fixed pattern, ready always high
      mode = 0;
      sample_ready = 1'b1;
      send_slot(1'b1, 4, rbits(16'h0), 0, -1);
      for (int f = 0; f < 2; f++) begin
         send_slot(1'b0, 31, rbits(16'hA5C3), 0, -1);
         send_slot(1'b1, 31, rbits(16'h1234), 0, -1);
      end
      send_slot(1'b0, 31, rbits(16'(($urandom()))), 0, -1);
      repeat (8) @(negedge clk);
      check("locked_after_frames", 32'(locked), 32'h1);

      // random data with varying slot lengths, including short slots
      for (int k = 0; k < 5; k++) begin
         send_slot(1'b1, int'($urandom_range(10, 31)), rbits(16'($urandom())), 0, -1);
         send_slot(1'b0, int'($urandom_range(10, 31)), rbits(16'($urandom())), 0, -1);
      end

      // 12-bit left slot of all ones is zero-padded
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      b = {$urandom(), $urandom()};
      b[63:52] = 12'hFFF;
      send_slot(1'b0, 12, b, 0, -1);
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      repeat (10) @(negedge clk);
      check("short_slot_left", 32'(left_data), 32'h0000FFF0);
      check("drained_1", 32'(exp_q.size()), 32'h0);

      // reset in the middle of a right slot
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, 10);
      check("midrst_valid", 32'(sample_valid), 32'h0);
      check("midrst_overrun", 32'(overrun), 32'h0);
      check("midrst_locked", 32'(locked), 32'h0);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      repeat (10) @(negedge clk);
      check("midrst_drained", 32'(exp_q.size()), 32'h0);
      check("midrst_relock", 32'(locked), 32'h1);

      // consumer stalls across several frames
      mode = 1;
      sample_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
         send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      end
      check("hold_overrun", 32'(overrun), 32'h1);
      check("hold_valid", 32'(sample_valid), 32'h1);
      check("hold_left", 32'(left_data), 32'(held_l));
      check("hold_right", 32'(right_data), 32'(held_r));
      @(posedge clk);
      #1 overrun_clr = 1'b1;
      @(posedge clk);
      #1 overrun_clr = 1'b0;
      @(negedge clk);
      check("clr_overrun", 32'(overrun), 32'h0);
      check("clr_left", 32'(left_data), 32'(held_l));
      check("clr_right", 32'(right_data), 32'(held_r));
      pulse_ready();
      repeat (2) @(negedge clk);
      check("accept_valid", 32'(sample_valid), 32'h0);

      // ready coincides with a new pair completing
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      mode = 2;
      send_slot(1'b0, 31, rbits(16'($urandom())), 1, -1);
      check("hit_valid", 32'(sample_valid), 32'h1);
      check("hit_left", 32'(left_data), 32'(held_l));
      check("hit_right", 32'(right_data), 32'(held_r));
      check("hit_overrun", 32'(overrun), 32'h0);
      pulse_ready();
      repeat (4) @(negedge clk);
      check("drained_2", 32'(exp_q.size()), 32'h0);

      // lrclk stuck for 40 SCLKs drops lock, then one frame re-locks
      mode = 0;
      sample_ready = 1'b1;
      send_slot(1'b1, 39, rbits(16'($urandom())), 0, -1);
      check("tmo_locked", 32'(locked), 32'h0);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b1, 31, rbits(16'($urandom())), 0, -1);
      send_slot(1'b0, 31, rbits(16'($urandom())), 0, -1);
      repeat (10) @(negedge clk);
      check("relock", 32'(locked), 32'h1);
      check("drained_3", 32'(exp_q.size()), 32'h0);
      check("final_overrun", 32'(overrun), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
